mops_sdo_responder: RTL and testbench
=====================================

# mops_sdo_responder

Synthesizable MOPS-side CANopen SDO responder: the answering end of the SDO requests that MOPSHUB issues on each CAN bus. It accepts a decoded 76-bit request frame and checks the COB-ID against its node. It then serves expedited upload and download requests from a small object dictionary and returns a response frame through a request/acknowledge handshake. One instance per emulated bus sits beside `data_generator` in `mopshub_testbench`, replacing per-bus behavioural response code.

## Interface
Parameters:
- `RESP_DELAY`, 8'd4: idle cycles inserted between decode and `tx_req`; 0 is allowed.
- `DEVICE_TYPE`, 32'h0000_0000: value returned for object 0x1000:00.
- `N_ADC_CH`, 6'd35: highest valid ADC subindex.

Ports:
- `clk_40_m`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-low. Reset is rst, synchronous, active-low; clock is clk_40_m.
- `node_id`, in, 7: CANopen node ID of this MOPS.
- `base_adc`, in, 12: ADC model base value.
- `rx_frame`, in, 76: request frame. Bit [75] is RTR, [74:64] is COB-ID, [63:0] is payload bytes 0..7 (byte0 = [63:56]).
- `rx_valid`, in, 1: one-cycle strobe; `rx_frame` is valid while it is high.
- `tx_frame`, out, 76: response frame, same format as `rx_frame`.
- `tx_req`, out, 1: response pending.
- `tx_ack`, in, 1: consumer has taken the response.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `req_cnt`, out, 16: count of accepted requests.
- `drop_cnt`, out, 8: count of requests dropped while busy.

## Operation
- FSM states: IDLE, DECODE, WAIT, SEND.
- IDLE: `rx_valid`=1 with COB-ID == 0x600+`node_id` and RTR=0 latches the frame, increments `req_cnt` and moves to DECODE. Frames with a mismatched COB-ID or RTR set are ignored silently.
- DECODE (1 cycle): builds the response. Response COB-ID is 0x580+`node_id`, RTR=0. Index is little-endian from bytes 1-2; subindex is byte 3; bytes 1-3 are echoed into the response.
- Command 0x40 (upload) responses:
  - 0x1000:00 → cmd 0x43, data `DEVICE_TYPE`.
  - 0x2200:00 → cmd 0x43, data from `user_reg`.
  - 0x2400:sub with 1≤sub≤`N_ADC_CH` → cmd 0x4B, data {4'h0, (`base_adc`+sub) mod 4096} in bytes 4-5, bytes 6-7 zero.
- Commands 0x23/0x2B/0x2F (download) to 0x2200:00 write bytes 4-7 into `user_reg`. Unused bytes are zero-filled per size: 0x2B keeps bytes 4-5, 0x2F keeps byte 4. Response is cmd 0x60 with data 0.
- Aborts: cmd 0x80, abort code in bytes 4-7 little-endian.
  - Unknown object or subindex: 0x0602_0000.
  - Download to 0x1000 or 0x2400: 0x0601_0002.
  - Any other command byte: 0x0504_0001.
- WAIT: counts `RESP_DELAY` cycles. If `RESP_DELAY`=0, DECODE goes directly to SEND.
- SEND: `tx_req`=1 with `tx_frame` held stable. `tx_ack`=1 at an edge clears `tx_req` and returns the FSM to IDLE.
- `rx_valid` arriving in any state other than IDLE: the frame is dropped and `drop_cnt` increments. `drop_cnt` saturates at 255; `req_cnt` wraps.

## Timing
- Reset values: `tx_frame`=0, `tx_req`=0, `busy`=0, `req_cnt`=0, `drop_cnt`=0, `user_reg`=0, state IDLE.
- Reset asserted mid-transaction aborts it. `tx_req` is low after the next edge and no response is sent.
- Latency: `rx_valid` sampled at edge N → `tx_req` high after edge N+2+`RESP_DELAY`.
- `tx_ack` is ignored outside SEND. `tx_ack` may already be high on the first SEND cycle; `tx_req` then lasts exactly one cycle.
- An `rx_valid` on the same edge that SEND completes is dropped. An `rx_valid` on the first IDLE cycle is accepted.
- Download writes to `user_reg` take effect at the DECODE edge. An upload in the next transaction returns the new value.

## Structure
- Package `mops_sdo_pkg` holds:
  - frame field positions, plus SDO_RX_BASE=0x600 and SDO_TX_BASE=0x580;
  - command constants (0x40, 0x23, 0x2B, 0x2F, 0x43, 0x4B, 0x60, 0x80);
  - abort codes;
  - the object indices 0x1000, 0x2200, 0x2400;
  - the FSM state enum.
- Sub-module `mops_sdo_od`: object-dictionary lookup and ownership of `user_reg`. Takes cmd/index/subindex/data and returns response data, response cmd and an abort flag. The responder FSM instantiates it once.

## Test plan
- `node_id`=1, `base_adc`=12'h100; send 0x601 upload 0x2400:03 → one response with COB-ID 0x581, bytes 40→4B 00 24 03 03 01 00 00, `tx_req` at N+6 (`RESP_DELAY`=4).
- Download 0x23 to 0x2200:00 with data DEADBEEF, then upload it → responses 60 00 22 00 00000000, then 43 00 22 00 EF BE AD DE.
- Upload 0x2400:24 (subindex 36), and download to 0x1000:00 → aborts with codes 00 00 02 06 and 02 00 01 06 respectively.
- COB-ID 0x602 at `node_id`=1 → no response and `req_cnt` unchanged. Second valid request while in WAIT → `drop_cnt`=1 and only one response.
- Hold `tx_ack` low for 50 cycles → `tx_req` and `tx_frame` stay stable throughout. Pulse `rst` low during SEND → `tx_req`=0 and all counters 0 on the next edge.
- `RESP_DELAY`=0 with `tx_ack` tied high → `tx_req` high for exactly one cycle at N+2; 300 back-to-back spaced requests leave `req_cnt`=300 and `drop_cnt`=0.

Source files
------------

// File: rtl/mops_sdo_pkg.sv
// Shared definitions for the MOPS-side SDO responder: frame layout, SDO command
// bytes, abort codes, object indices and the responder FSM state type.
package mops_sdo_pkg;

    localparam int unsigned FRAME_W = 76;
    localparam int unsigned COB_W   = 11;
    localparam int unsigned RTR_POS = 75;
    localparam int unsigned COB_MSB = 74;
    localparam int unsigned COB_LSB = 64;

    localparam logic [COB_W-1:0] SDO_RX_BASE = 11'h600;
    localparam logic [COB_W-1:0] SDO_TX_BASE = 11'h580;

    localparam logic [7:0] CMD_UPLOAD     = 8'h40;
    localparam logic [7:0] CMD_DL_4       = 8'h23;
    localparam logic [7:0] CMD_DL_2       = 8'h2B;
    localparam logic [7:0] CMD_DL_1       = 8'h2F;
    localparam logic [7:0] CMD_UL_RESP_4  = 8'h43;
    localparam logic [7:0] CMD_UL_RESP_2  = 8'h4B;
    localparam logic [7:0] CMD_DL_RESP    = 8'h60;
    localparam logic [7:0] CMD_ABORT      = 8'h80;

    localparam logic [31:0] ABORT_NO_OBJ  = 32'h0602_0000;
    localparam logic [31:0] ABORT_RO      = 32'h0601_0002;
    localparam logic [31:0] ABORT_BAD_CMD = 32'h0504_0001;

    localparam logic [15:0] IDX_DEVICE_TYPE = 16'h1000;
    localparam logic [15:0] IDX_USER_REG    = 16'h2200;
    localparam logic [15:0] IDX_ADC         = 16'h2400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_SEND
    } sdo_state_t;

    // Payload bytes 0..7, byte0 in the most significant position
    typedef struct packed {
        logic [7:0]  cmd;
        logic [7:0]  idx_lo;
        logic [7:0]  idx_hi;
        logic [7:0]  sub;
        logic [31:0] data;
    } sdo_payload_t;

    typedef struct packed {
        logic             rtr;
        logic [COB_W-1:0] cob_id;
        sdo_payload_t     payload;
    } sdo_frame_t;

    // Converts between a 32-bit value and its little-endian byte order on the wire
    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/mops_sdo_od.sv
// Object dictionary of the emulated MOPS: resolves one SDO request into a
// response command/value and owns the writable user register.
module mops_sdo_od
    import mops_sdo_pkg::*;
#(
    parameter logic [31:0] DEVICE_TYPE = 32'h0000_0000,
    parameter logic [5:0]  N_ADC_CH    = 6'd35
) (
    input  logic        clk_40_m,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [7:0]  i_cmd,
    input  logic [15:0] i_index,
    input  logic [7:0]  i_sub,
    input  logic [31:0] i_data,
    input  logic [11:0] i_base_adc,
    output logic [7:0]  o_resp_cmd_c,
    output logic [31:0] o_resp_data_c,
    output logic        o_abort_c
);

    logic [31:0] r_user_reg;
    logic        w_dl_ok;
    logic [31:0] w_dl_val;
    logic [11:0] w_adc;

    // Lookup; values are native order, the caller puts them on the wire little-endian
    always_comb begin
        o_resp_cmd_c  = CMD_ABORT;
        o_resp_data_c = ABORT_BAD_CMD;
        o_abort_c     = 1'b1;
        w_dl_ok       = 1'b0;
        w_adc         = 12'(i_base_adc + 12'(i_sub));
        w_dl_val      = i_data;

        case (i_cmd)
            CMD_UPLOAD: begin
                o_resp_data_c = ABORT_NO_OBJ;
                if (i_index == IDX_DEVICE_TYPE && i_sub == 8'h00) begin
                    o_resp_cmd_c  = CMD_UL_RESP_4;
                    o_resp_data_c = DEVICE_TYPE;
                    o_abort_c     = 1'b0;
                end else if (i_index == IDX_USER_REG && i_sub == 8'h00) begin
                    o_resp_cmd_c  = CMD_UL_RESP_4;
                    o_resp_data_c = r_user_reg;
                    o_abort_c     = 1'b0;
                end else if (i_index == IDX_ADC && i_sub != 8'h00 && i_sub <= 8'(N_ADC_CH)) begin
                    o_resp_cmd_c  = CMD_UL_RESP_2;
                    o_resp_data_c = {16'h0000, 4'h0, w_adc};
                    o_abort_c     = 1'b0;
                end
            end
            CMD_DL_4, CMD_DL_2, CMD_DL_1: begin
                if (i_index == IDX_USER_REG && i_sub == 8'h00) begin
                    w_dl_ok       = 1'b1;
                    o_resp_cmd_c  = CMD_DL_RESP;
                    o_resp_data_c = 32'h0000_0000;
                    o_abort_c     = 1'b0;
                end else if (i_index == IDX_DEVICE_TYPE || i_index == IDX_ADC) begin
                    o_resp_data_c = ABORT_RO;
                end else begin
                    o_resp_data_c = ABORT_NO_OBJ;
                end
            end
            default: ;
        endcase

        // Short downloads only carry their low bytes; the rest reads as zero
        if (i_cmd == CMD_DL_2) begin
            w_dl_val = {16'h0000, i_data[15:0]};
        end else if (i_cmd == CMD_DL_1) begin
            w_dl_val = {24'h00_0000, i_data[7:0]};
        end
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_user_reg <= 32'h0000_0000;
        end else if (i_wr_en && w_dl_ok) begin
            r_user_reg <= w_dl_val;
        end
    end

endmodule

// File: rtl/mops_sdo_responder.sv
// Answers MOPSHUB SDO requests addressed to this node with expedited
// upload/download responses, handed out through a tx_req/tx_ack handshake.
module mops_sdo_responder
    import mops_sdo_pkg::*;
#(
    parameter logic [7:0]  RESP_DELAY  = 8'd4,
    parameter logic [31:0] DEVICE_TYPE = 32'h0000_0000,
    parameter logic [5:0]  N_ADC_CH    = 6'd35
) (
    input  logic               clk_40_m,
    input  logic               rst,
    input  logic [6:0]         node_id,
    input  logic [11:0]        base_adc,
    input  logic [FRAME_W-1:0] rx_frame,
    input  logic               rx_valid,
    output logic [FRAME_W-1:0] tx_frame,
    output logic               tx_req,
    input  logic               tx_ack,
    output logic               busy,
    output logic [15:0]        req_cnt,
    output logic [7:0]         drop_cnt
);

    sdo_state_t         r_state;
    sdo_state_t         w_state_nxt;
    sdo_payload_t       r_req;
    logic [7:0]         r_wait_cnt;
    logic [FRAME_W-1:0] r_tx_frame;
    logic               r_tx_req;
    logic               r_busy;
    logic [15:0]        r_req_cnt;
    logic [7:0]         r_drop_cnt;

    logic [COB_W-1:0]   w_rx_cob;
    logic [COB_W-1:0]   w_tx_cob;
    logic               w_accept;
    logic               w_drop;
    logic [7:0]         w_od_cmd;
    logic [31:0]        w_od_data;
    logic               w_od_abort;
    sdo_frame_t         w_resp;

    assign w_rx_cob = SDO_RX_BASE + 11'(node_id);
    assign w_tx_cob = SDO_TX_BASE + 11'(node_id);
    assign w_accept = rx_valid && (r_state == ST_IDLE) && !rx_frame[RTR_POS]
                   && (rx_frame[COB_MSB:COB_LSB] == w_rx_cob);
    assign w_drop   = rx_valid && (r_state != ST_IDLE);

    mops_sdo_od #(
        .DEVICE_TYPE (DEVICE_TYPE),
        .N_ADC_CH    (N_ADC_CH)
    ) u_od (
        .clk_40_m      (clk_40_m),
        .rst           (rst),
        .i_wr_en       (r_state == ST_DECODE),
        .i_cmd         (r_req.cmd),
        .i_index       ({r_req.idx_hi, r_req.idx_lo}),
        .i_sub         (r_req.sub),
        .i_data        (swap32(r_req.data)),
        .i_base_adc    (base_adc),
        .o_resp_cmd_c  (w_od_cmd),
        .o_resp_data_c (w_od_data),
        .o_abort_c     (w_od_abort)
    );

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the response frame assembled during DECODE
    always_comb begin
        w_state_nxt = r_state;
        w_resp      = '0;

        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_DECODE;
            ST_DECODE: w_state_nxt = (RESP_DELAY == 8'd0) ? ST_SEND : ST_WAIT;
            ST_WAIT:   if (r_wait_cnt <= 8'd1) w_state_nxt = ST_SEND;
            ST_SEND:   if (r_tx_req && tx_ack) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        w_resp.rtr            = 1'b0;
        w_resp.cob_id         = w_tx_cob;
        w_resp.payload.cmd    = w_od_abort ? CMD_ABORT : w_od_cmd;
        w_resp.payload.idx_lo = r_req.idx_lo;
        w_resp.payload.idx_hi = r_req.idx_hi;
        w_resp.payload.sub    = r_req.sub;
        w_resp.payload.data   = swap32(w_od_data);
    end

    // tx_req rises on the second SEND cycle and drops on the acknowledging edge
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_req      <= '0;
            r_wait_cnt <= 8'd0;
            r_tx_frame <= '0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_req_cnt  <= 16'd0;
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_accept) begin
                r_req     <= rx_frame[COB_LSB-1:0];
                r_req_cnt <= r_req_cnt + 16'd1;
            end
            if (r_state == ST_DECODE) begin
                r_tx_frame <= w_resp;
                r_wait_cnt <= RESP_DELAY;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 8'd1;
            end
            r_tx_req <= (r_state == ST_SEND) && !(r_tx_req && tx_ack);
            r_busy   <= (w_state_nxt != ST_IDLE);
            if (w_drop && r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign tx_frame = r_tx_frame;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;
    assign req_cnt  = r_req_cnt;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_mops_sdo_responder.sv
// Self-checking bench for mops_sdo_responder: a RESP_DELAY=4 instance driven by
// scenario tasks and a RESP_DELAY=0 instance with tx_ack tied high.
module tb_mops_sdo_responder;

    logic        clk_40_m = 1'b0;
    logic        rst;
    logic [6:0]  node_id;
    logic [11:0] base_adc;
    logic [75:0] rx_frame, rx_frame0;
    logic        rx_valid, rx_valid0;
    logic [75:0] tx_frame, tx_frame0;
    logic        tx_req, tx_req0;
    logic        tx_ack;
    logic        busy, busy0;
    logic [15:0] req_cnt, req_cnt0;
    logic [7:0]  drop_cnt, drop_cnt0;

    int          n_cmp = 0;
    int          n_err = 0;
    int          resp_cnt = 0;
    int          resp0_cnt = 0;
    logic [15:0] exp_req = 16'd0;
    logic [75:0] exp_q[$];
    logic [75:0] exp0_q[$];
    logic [75:0] mon_exp, mon0_exp;
    logic        mon_prev = 1'b0;
    logic        mon0_prev = 1'b0;

    always #5 clk_40_m = ~clk_40_m;

    mops_sdo_responder #(
        .DEVICE_TYPE (32'h0002_0191)
    ) u_dut (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .node_id  (node_id),
        .base_adc (base_adc),
        .rx_frame (rx_frame),
        .rx_valid (rx_valid),
        .tx_frame (tx_frame),
        .tx_req   (tx_req),
        .tx_ack   (tx_ack),
        .busy     (busy),
        .req_cnt  (req_cnt),
        .drop_cnt (drop_cnt)
    );

    mops_sdo_responder #(
        .RESP_DELAY (8'd0)
    ) u_dut0 (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .node_id  (node_id),
        .base_adc (base_adc),
        .rx_frame (rx_frame0),
        .rx_valid (rx_valid0),
        .tx_frame (tx_frame0),
        .tx_req   (tx_req0),
        .tx_ack   (1'b1),
        .busy     (busy0),
        .req_cnt  (req_cnt0),
        .drop_cnt (drop_cnt0)
    );

    // Scoreboards: every new response pops the oldest expected frame
    always @(negedge clk_40_m) begin
        if (tx_req === 1'b1 && !mon_prev) begin
            resp_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected: got %h, expected no response", tx_frame);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tx_frame !== mon_exp) begin
                    n_err++;
                    $display("FAIL resp_frame: got %h, expected %h", tx_frame, mon_exp);
                end
            end
        end
        mon_prev = (tx_req === 1'b1);
    end

    always @(negedge clk_40_m) begin
        if (tx_req0 === 1'b1 && !mon0_prev) begin
            resp0_cnt++;
            n_cmp++;
            if (exp0_q.size() == 0) begin
                n_err++;
                $display("FAIL resp0_unexpected: got %h, expected no response", tx_frame0);
            end else begin
                mon0_exp = exp0_q.pop_front();
                if (tx_frame0 !== mon0_exp) begin
                    n_err++;
                    $display("FAIL resp0_frame: got %h, expected %h", tx_frame0, mon0_exp);
                end
            end
        end
        mon0_prev = (tx_req0 === 1'b1);
    end

    function automatic logic [75:0] mk(input logic [10:0] cob, input logic [63:0] pl);
        return {1'b0, cob, pl};
    endfunction

    task automatic tick();
        @(posedge clk_40_m);
        #1;
    endtask

    task automatic send(input logic [75:0] f);
        rx_frame = f;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send0(input logic [75:0] f);
        rx_frame0 = f;
        rx_valid0 = 1'b1;
        tick();
        rx_valid0 = 1'b0;
    endtask

    // Cycles until tx_req is seen (-1 when the bound expires)
    task automatic wait_req(input int max_cyc, output int k);
        k = 0;
        while (tx_req !== 1'b1 && k < max_cyc) begin
            tick();
            k++;
        end
        if (tx_req !== 1'b1) k = -1;
    endtask

    task automatic ack();
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
    endtask

    task automatic do_txn(input logic [75:0] req, input logic [75:0] exp, output int k);
        exp_q.push_back(exp);
        send(req);
        wait_req(40, k);
        if (k >= 0) ack();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_cmp += 5;
        if (tx_req !== 1'b0) begin n_err++; $display("FAIL reset_tx_req: got %b, expected 0", tx_req); end
        if (tx_frame !== 76'd0) begin n_err++; $display("FAIL reset_tx_frame: got %h, expected 0", tx_frame); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (req_cnt !== 16'd0) begin n_err++; $display("FAIL reset_req_cnt: got %0d, expected 0", req_cnt); end
        if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop_cnt: got %0d, expected 0", drop_cnt); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_adc_upload();
        int k;
        exp_q.push_back(mk(11'h581, 64'h4B00_2403_0301_0000));
        send(mk(11'h601, 64'h4000_2403_0000_0000));
        exp_req++;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL adc_busy: got %b, expected 1", busy); end
        wait_req(40, k);
        n_cmp++;
        if (k != 6) begin n_err++; $display("FAIL adc_latency: got %0d cycles, expected 6", k); end
        if (k >= 0) ack();
        n_cmp += 3;
        if (tx_req !== 1'b0) begin n_err++; $display("FAIL adc_req_clear: got %b, expected 0", tx_req); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL adc_busy_clear: got %b, expected 0", busy); end
        if (req_cnt !== exp_req) begin n_err++; $display("FAIL adc_req_cnt: got %0d, expected %0d", req_cnt, exp_req); end
    endtask

    task automatic test_download_upload();
        logic [63:0] rq [0:5];
        logic [63:0] rs [0:5];
        int k;
        rq = '{64'h2300_2200_EFBE_ADDE, 64'h4000_2200_0000_0000, 64'h2B00_2200_1122_3344,
               64'h4000_2200_0000_0000, 64'h2F00_2200_AABB_CCDD, 64'h4000_2200_0000_0000};
        rs = '{64'h6000_2200_0000_0000, 64'h4300_2200_EFBE_ADDE, 64'h6000_2200_0000_0000,
               64'h4300_2200_1122_0000, 64'h6000_2200_0000_0000, 64'h4300_2200_AA00_0000};
        for (int i = 0; i < 6; i++) begin
            do_txn(mk(11'h601, rq[i]), mk(11'h581, rs[i]), k);
            exp_req++;
            n_cmp++;
            if (k < 0) begin n_err++; $display("FAIL dlul_timeout[%0d]: got no tx_req, expected one", i); end
        end
        n_cmp++;
        if (req_cnt !== exp_req) begin n_err++; $display("FAIL dlul_req_cnt: got %0d, expected %0d", req_cnt, exp_req); end
    endtask

    task automatic test_aborts();
        logic [63:0] rq [0:9];
        logic [63:0] rs [0:9];
        int k;
        rq = '{64'h4000_2424_0000_0000, 64'h2300_1000_0102_0304, 64'h2B00_2405_0102_0304,
               64'h9900_1000_0000_0000, 64'h4000_2400_0000_0000, 64'h4000_3000_0000_0000,
               64'h4000_2423_0000_0000, 64'h4000_1000_0000_0000, 64'h4000_2201_0000_0000,
               64'h2300_2201_5555_5555};
        rs = '{64'h8000_2424_0000_0206, 64'h8000_1000_0200_0106, 64'h8000_2405_0200_0106,
               64'h8000_1000_0100_0405, 64'h8000_2400_0000_0206, 64'h8000_3000_0000_0206,
               64'h4B00_2423_2301_0000, 64'h4300_1000_9101_0200, 64'h8000_2201_0000_0206,
               64'h8000_2201_0000_0206};
        for (int i = 0; i < 10; i++) begin
            do_txn(mk(11'h601, rq[i]), mk(11'h581, rs[i]), k);
            exp_req++;
            n_cmp++;
            if (k < 0) begin n_err++; $display("FAIL abort_timeout[%0d]: got no tx_req, expected one", i); end
        end
    endtask

    task automatic test_filter();
        logic seen;
        int   r0;
        r0   = resp_cnt;
        seen = 1'b0;
        send(mk(11'h602, 64'h4000_2403_0000_0000));
        repeat (20) begin
            if (tx_req !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        send({1'b1, 11'h601, 64'h4000_2403_0000_0000});
        repeat (20) begin
            if (tx_req !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        n_cmp += 3;
        if (seen !== 1'b0) begin n_err++; $display("FAIL filter_activity: got activity, expected none"); end
        if (req_cnt !== exp_req) begin n_err++; $display("FAIL filter_req_cnt: got %0d, expected %0d", req_cnt, exp_req); end
        if (resp_cnt != r0) begin n_err++; $display("FAIL filter_resp: got %0d responses, expected 0", resp_cnt - r0); end
    endtask

    task automatic test_drop();
        int k;
        int r0;
        r0 = resp_cnt;
        exp_q.push_back(mk(11'h581, 64'h4300_1000_9101_0200));
        send(mk(11'h601, 64'h4000_1000_0000_0000));
        exp_req++;
        tick();
        send(mk(11'h601, 64'h4000_2403_0000_0000));
        wait_req(40, k);
        if (k >= 0) ack();
        n_cmp += 2;
        if (k < 0) begin n_err++; $display("FAIL drop_wait_timeout: got no tx_req, expected one"); end
        if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL drop_cnt_wait: got %0d, expected 1", drop_cnt); end

        // Request on the acknowledging edge is dropped; the next cycle is accepted
        exp_q.push_back(mk(11'h581, 64'h4B00_2401_0101_0000));
        send(mk(11'h601, 64'h4000_2401_0000_0000));
        exp_req++;
        wait_req(40, k);
        tx_ack   = 1'b1;
        rx_frame = mk(11'h601, 64'h4000_2403_0000_0000);
        rx_valid = 1'b1;
        tick();
        tx_ack   = 1'b0;
        rx_valid = 1'b0;
        n_cmp += 3;
        if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL drop_cnt_send: got %0d, expected 2", drop_cnt); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy: got %b, expected 0", busy); end
        if (tx_req !== 1'b0) begin n_err++; $display("FAIL drop_req_clear: got %b, expected 0", tx_req); end
        exp_q.push_back(mk(11'h581, 64'h4B00_2402_0201_0000));
        send(mk(11'h601, 64'h4000_2402_0000_0000));
        exp_req++;
        wait_req(40, k);
        n_cmp++;
        if (k != 6) begin n_err++; $display("FAIL drop_first_idle_latency: got %0d, expected 6", k); end
        if (k >= 0) ack();
        repeat (20) tick();
        n_cmp += 2;
        if (resp_cnt - r0 != 3) begin n_err++; $display("FAIL drop_resp_count: got %0d, expected 3", resp_cnt - r0); end
        if (req_cnt !== exp_req) begin n_err++; $display("FAIL drop_req_cnt: got %0d, expected %0d", req_cnt, exp_req); end
    endtask

    task automatic test_stall();
        logic [75:0] exp;
        logic        stable;
        int          k;
        exp = mk(11'h581, 64'h4300_2200_AA00_0000);
        exp_q.push_back(exp);
        send(mk(11'h601, 64'h4000_2200_0000_0000));
        exp_req++;
        wait_req(40, k);
        stable = (k >= 0);
        repeat (50) begin
            if (tx_req !== 1'b1 || tx_frame !== exp) stable = 1'b0;
            tick();
        end
        n_cmp++;
        if (stable !== 1'b1) begin n_err++; $display("FAIL stall_stable: got tx_req=%b frame=%h, expected 1 and %h", tx_req, tx_frame, exp); end
        ack();
        n_cmp++;
        if (tx_req !== 1'b0) begin n_err++; $display("FAIL stall_req_clear: got %b, expected 0", tx_req); end
    endtask

    task automatic test_reset_mid();
        int k;
        int r0;
        exp_q.push_back(mk(11'h581, 64'h4B00_2401_0101_0000));
        send(mk(11'h601, 64'h4000_2401_0000_0000));
        wait_req(40, k);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_req = 16'd0;
        n_cmp += 6;
        if (k < 0) begin n_err++; $display("FAIL rstmid_timeout: got no tx_req, expected one"); end
        if (tx_req !== 1'b0) begin n_err++; $display("FAIL rstmid_tx_req: got %b, expected 0", tx_req); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        if (req_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_req_cnt: got %0d, expected 0", req_cnt); end
        if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rstmid_drop_cnt: got %0d, expected 0", drop_cnt); end
        if (tx_frame !== 76'd0) begin n_err++; $display("FAIL rstmid_tx_frame: got %h, expected 0", tx_frame); end
        r0 = resp_cnt;
        repeat (20) tick();
        n_cmp++;
        if (resp_cnt != r0) begin n_err++; $display("FAIL rstmid_no_resp: got %0d responses, expected 0", resp_cnt - r0); end
        do_txn(mk(11'h601, 64'h4000_2200_0000_0000), mk(11'h581, 64'h4300_2200_0000_0000), k);
        exp_req++;
        n_cmp++;
        if (req_cnt !== exp_req) begin n_err++; $display("FAIL rstmid_req_cnt_after: got %0d, expected %0d", req_cnt, exp_req); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  sub;
        logic [11:0] val;
        int          k;
        base_adc = 12'hFF0;
        for (int i = 0; i < 300; i++) begin
            sub = 8'((i % 35) + 1);
            val = 12'(12'hFF0 + 12'(sub));
            exp0_q.push_back(mk(11'h581, {8'h4B, 8'h00, 8'h24, sub, val[7:0], {4'h0, val[11:8]}, 16'h0000}));
            send0(mk(11'h601, {8'h40, 8'h00, 8'h24, sub, 32'h0000_0000}));
            k = 0;
            while (tx_req0 !== 1'b1 && k < 10) begin
                tick();
                k++;
            end
            n_cmp++;
            if (k != 2) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d cycles, expected 2", i, k); end
            tick();
            n_cmp++;
            if (tx_req0 !== 1'b0) begin n_err++; $display("FAIL b2b_req_width[%0d]: got %b, expected 0", i, tx_req0); end
        end
        repeat (5) tick();
        n_cmp += 3;
        if (req_cnt0 !== 16'd300) begin n_err++; $display("FAIL b2b_req_cnt: got %0d, expected 300", req_cnt0); end
        if (drop_cnt0 !== 8'd0) begin n_err++; $display("FAIL b2b_drop_cnt: got %0d, expected 0", drop_cnt0); end
        if (resp0_cnt != 300) begin n_err++; $display("FAIL b2b_resp_count: got %0d, expected 300", resp0_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        node_id   = 7'd1;
        base_adc  = 12'h100;
        rx_frame  = '0;
        rx_valid  = 1'b0;
        rx_frame0 = '0;
        rx_valid0 = 1'b0;
        tx_ack    = 1'b0;
        #1;
        test_reset();
        test_adc_upload();
        test_download_upload();
        test_aborts();
        test_filter();
        test_drop();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        n_cmp += 2;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover_expected: got %0d pending, expected 0", exp_q.size()); end
        if (exp0_q.size() != 0) begin n_err++; $display("FAIL leftover_expected0: got %0d pending, expected 0", exp0_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
